// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state type and the
// byte value presented on tx_data while nothing has been granted.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } uart_state_e;

  localparam logic [7:0] UART_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/rr_pick.sv
// Winner search for the UART transmit arbiter.
// Default build: round-robin, search starts at last+1 and wraps at N_REQ.
// With UART_TX_ARB_FIXED_PRIO_EN defined: lowest set request index wins and
// 'last' is ignored.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             valid,
  output logic [IW-1:0]    idx
);

`ifdef UART_TX_ARB_FIXED_PRIO_EN

  // Fixed priority: scan from the top so the lowest set index is written last.
  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

`else

  // One extra bit so last+k (at most 2*N_REQ-1) cannot overflow before the wrap.
  logic [IW:0] cand;

  // Round-robin: visit last+1 .. last+N_REQ modulo N_REQ, first set bit wins.
  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (!valid && req[cand[IW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

`endif

endmodule

// File: rtl/uart_tx_arb.sv
// Arbiter sharing one UART transmitter between N_REQ byte requesters.
// A grant latches the winner's byte, pulses its ack, raises tx_flag for one
// cycle, then follows the transmitter's busy handshake back to IDLE.
// Macro UART_TX_ARB_FIXED_PRIO_EN selects fixed priority instead of
// round-robin (see rr_pick).
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [7:0]         tx_data,
  output logic               tx_flag,
  input  logic               tx_busy,
  output logic [IW-1:0]      grant_id,
  output logic               active
);

  uart_state_e   state;
  uart_state_e   state_nxt;
  logic [IW-1:0] last_grant;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          grant;
  logic [7:0]    win_byte;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req   (req_valid),
    .last  (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Requests are only evaluated in IDLE with the transmitter free, so any
  // req_valid activity during a frame is simply not looked at.
  assign grant = (state == IDLE) && !tx_busy && pick_valid;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic following the transmitter's start/busy handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant)    state_nxt = ISSUE;
      ISSUE:                   state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Select the winning requester's byte out of the packed data bus.
  always_comb begin
    win_byte = UART_IDLE_BYTE;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        win_byte = req_data[8*i +: 8];
      end
    end
  end

  // Capture the granted byte and owner; they hold until the next grant.
  // last_grant resets to N_REQ-1 so requester 0 is searched first.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tx_data    <= UART_IDLE_BYTE;
      grant_id   <= '0;
      last_grant <= IW'(N_REQ - 1);
    end else if (grant) begin
      tx_data    <= win_byte;
      grant_id   <= pick_idx;
      last_grant <= pick_idx;
    end
  end

  // Outputs decoded from state: start pulse and ack live only in ISSUE.
  always_comb begin
    tx_flag = (state == ISSUE);
    active  = (state != IDLE);
    req_ack = '0;
    if (state == ISSUE) begin
      req_ack[grant_id] = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus a randomized
// run, all checked against a transaction-level reference model and a simple
// behavioural transmitter that answers tx_flag with a busy window.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           CLK = 1'b0;
  logic           RESET_N;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [7:0]     tx_data;
  logic           tx_flag;
  logic           tx_busy;
  logic [IW-1:0]  grant_id;
  logic           active;

  always #5 CLK = ~CLK;

  uart_tx_arb #(
    .N_REQ (N),
    .IW    (IW)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_flag   (tx_flag),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Requester byte registers, packed onto req_data.
  logic [7:0] rq_byte [N];

  task automatic pack_data();
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = rq_byte[i];
  endtask

  // ---------------- reference model ----------------
  // m_phase: 0 arbiter free, 1 start pulse, 2 waiting for transmitter to
  // report busy, 3 waiting for the transmitter to finish.
  int         m_phase;
  int         m_last;
  int         m_id;
  logic [7:0] m_byte;
  logic [N-1:0] m_ack;

  function automatic int pick_winner(input logic [N-1:0] v, input int last);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
`endif
    return 0;
  endfunction

  task automatic model_edge();
    m_ack = '0;
    if (!RESET_N) begin
      m_phase = 0;
      m_last  = N - 1;
      m_id    = 0;
      m_byte  = 8'hFF;
    end else begin
      case (m_phase)
        0: if (!tx_busy && req_valid != '0) begin
             m_id        = pick_winner(req_valid, m_last);
             m_last      = m_id;
             m_byte      = rq_byte[m_id];
             m_ack[m_id] = 1'b1;
             m_phase     = 1;
           end
        1: m_phase = 2;
        2: if (tx_busy)  m_phase = 3;
        3: if (!tx_busy) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  endtask

  // ---------------- transmitter model ----------------
  bit xm_on;
  int xm_wait;
  int xm_len;
  int ext_busy;
  int flags_seen;
  int acks_seen;

  task automatic xmit_step();
    logic b;
    b = 1'b0;
    if (!RESET_N) begin
      xm_on    = 0;
      ext_busy = 0;
      tx_busy  = 1'b0;
      return;
    end
    if (tx_flag) begin
      check("flag_during_frame", 32'(xm_on), 32'd0);
      flags_seen++;
      xm_on   = 1;
      xm_wait = $urandom_range(0, 2);
      xm_len  = $urandom_range(2, 5);
    end
    if (xm_on) begin
      if (xm_wait > 0) xm_wait--;
      else if (xm_len > 0) begin
        b = 1'b1;
        xm_len--;
      end else xm_on = 0;
    end
    if (ext_busy > 0) begin
      b = 1'b1;
      ext_busy--;
    end
    tx_busy = b;
  endtask

  // One clock: model follows the rising edge, outputs compared on the falling
  // edge, then the transmitter reacts for the next edge.
  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check("req_ack",  32'(req_ack),  32'(m_ack));
    check("tx_flag",  32'(tx_flag),  32'(m_phase == 1));
    check("active",   32'(active),   32'(m_phase != 0));
    check("tx_data",  32'(tx_data),  32'(m_byte));
    check("grant_id", 32'(grant_id), 32'(m_id));
    if (req_ack != '0) acks_seen++;
    xmit_step();
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100; c++) begin
      if (m_phase == 0 && !xm_on && ext_busy == 0 && !tx_busy) return;
      cycle();
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic requesters_step();
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
        else rq_byte[i] = 8'($urandom);
      end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        rq_byte[i]   = 8'($urandom);
      end
    end
    pack_data();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got[$];
    int exp_seq[5];
    int first_ack;
    int busy_low_at;
    logic b_before;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif

    RESET_N   = 1'b0;
    req_valid = '0;
    tx_busy   = 1'b0;
    for (int i = 0; i < N; i++) rq_byte[i] = 8'h00;
    pack_data();
    xm_on = 0; xm_wait = 0; xm_len = 0; ext_busy = 0;
    flags_seen = 0; acks_seen = 0;
    m_phase = 0; m_last = N - 1; m_id = 0; m_byte = 8'hFF; m_ack = '0;

    // Reset state.
    repeat (3) cycle();
    check("rst_tx_data", 32'(tx_data),  32'hFF);
    check("rst_flag",    32'(tx_flag),  32'd0);
    check("rst_ack",     32'(req_ack),  32'd0);
    check("rst_active",  32'(active),   32'd0);
    check("rst_grant",   32'(grant_id), 32'd0);
    RESET_N = 1'b1;

    // Single request from requester 2.
    req_valid  = 4'b0100;
    rq_byte[2] = 8'h41;
    pack_data();
    cycle();
    check("single_ack",  32'(req_ack),  32'h4);
    check("single_flag", 32'(tx_flag),  32'd1);
    check("single_data", 32'(tx_data),  32'h41);
    check("single_id",   32'(grant_id), 32'd2);
    req_valid = '0;
    cycle();
    check("single_ack_pulse",  32'(req_ack), 32'd0);
    check("single_flag_pulse", 32'(tx_flag), 32'd0);
    wait_idle();

    // All four requesting continuously after a fresh reset.
    RESET_N = 1'b0;
    cycle();
    RESET_N = 1'b1;
    for (int i = 0; i < N; i++) rq_byte[i] = 8'(8'h10 + i);
    pack_data();
    req_valid = 4'hF;
    for (int c = 0; c < 300 && got.size() < 5; c++) begin
      cycle();
      if (req_ack != '0) got.push_back(int'(grant_id));
    end
    check("order_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size(); i++) check($sformatf("order_%0d", i), 32'(got[i]), 32'(exp_seq[i]));
    req_valid = '0;
    wait_idle();

    // Request raised while the transmitter is busy.
    ext_busy   = 6;
    tx_busy    = 1'b1;
    req_valid  = 4'b1000;
    rq_byte[3] = 8'h5A;
    pack_data();
    first_ack   = -1;
    busy_low_at = -1;
    for (int c = 0; c < 30; c++) begin
      b_before = tx_busy;
      cycle();
      if (req_ack != '0 && first_ack < 0) first_ack = c;
      if (!b_before && busy_low_at < 0) busy_low_at = c;
      if (req_ack[3]) req_valid[3] = 1'b0;
    end
    check("busy_low_seen", 32'(busy_low_at), 32'd7);
    check("ack_after_busy", 32'(first_ack), 32'(busy_low_at));
    wait_idle();

    // Reset while the transmitter is mid-frame.
    req_valid  = 4'b0010;
    rq_byte[1] = 8'hC3;
    pack_data();
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (req_ack != '0) req_valid = '0;
      if (m_phase == 3) break;
    end
    check("reached_wait_done", 32'(m_phase), 32'd3);
    RESET_N   = 1'b0;
    req_valid = 4'hF;
    cycle();
    check("midrst_active", 32'(active),   32'd0);
    check("midrst_flag",   32'(tx_flag),  32'd0);
    check("midrst_data",   32'(tx_data),  32'hFF);
    check("midrst_ack",    32'(req_ack),  32'd0);
    check("midrst_grant",  32'(grant_id), 32'd0);
    RESET_N   = 1'b1;
    first_ack = -1;
    for (int c = 0; c < 40 && first_ack < 0; c++) begin
      cycle();
      if (req_ack != '0) first_ack = int'(grant_id);
    end
    check("first_after_rst", 32'(first_ack), 32'd0);
    req_valid = '0;
    wait_idle();

    // Randomized traffic with busy interference and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      requesters_step();
      if (m_phase == 0 && ext_busy == 0 && $urandom_range(0, 19) == 0) ext_busy = $urandom_range(1, 3);
      RESET_N = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cycle();
    end
    RESET_N   = 1'b1;
    req_valid = '0;
    wait_idle();
    check("frames_vs_acks", 32'(flags_seen), 32'(acks_seen));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
